// File: rtl/cwc_trace_reader.sv
// ChipWatcher trace read-back engine (jtck domain).
// Once capture has stopped, this block walks the trace RAM in chronological
// order, oldest sample first, and serialises each sample LSB-first onto jtdo.
// A one-word prefetch keeps a continuously shifting host fed with no idle
// bits between samples.
// Optional build macro CWC_RD_HEADER_EN: adds a 32-bit header
// {16'hC57A, word_count[15:0]} in front of the first sample.
module cwc_trace_reader #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int SCAN_SEL   = 1
) (
    input  logic                  jtck,
    input  logic                  jrstn,
    input  logic [1:0]            jscan,
    input  logic                  jshift,
    input  logic                  jupdate,
    input  logic                  jtdi,
    output logic                  jtdo,
    input  logic                  cap_done,
    input  logic                  cap_wrap,
    input  logic [ADDR_WIDTH-1:0] cap_last_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_busy,
    output logic                  rd_done
);

`ifdef CWC_RD_HEADER_EN
    localparam int HDR_W = 32;
`else
    localparam int HDR_W = 0;
`endif
    // Word counters need one extra bit so that a full RAM (DEPTH words) fits.
    localparam int CW  = ADDR_WIDTH + 1;
    // The first word out carries the optional header in front of the sample.
    localparam int SW  = DATA_WIDTH + HDR_W;
    localparam int BCW = $clog2(SW + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SHIFT, S_DONE} state_t;

    // Trace RAM addresses wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    state_t                state_q,   state_d;
    logic [1:0]            pcnt_q,    pcnt_d;
    logic [SW-1:0]         shift_q,   shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  first_q,   first_d;
    logic [DATA_WIDTH-1:0] hold_q,    hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [CW-1:0]         rem_q,     rem_d;
    logic [CW-1:0]         reads_q,   reads_d;
    logic                  rd_en_q,   rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  pend_q,    pend_d;

    logic                  sel;
    logic                  arm;
    logic [ADDR_WIDTH-1:0] arm_start;
    logic [CW-1:0]         arm_rem;
    logic [BCW-1:0]        bit_last;
    logic [DATA_WIDTH-1:0] word_src;
    logic [SW-1:0]         first_load;
    logic                  unused_inputs;

    assign sel       = jscan[SCAN_SEL];
    assign arm       = jupdate & sel & cap_done;
    // Oldest sample sits just after the last write once the pointer has wrapped.
    assign arm_start = cap_wrap ? addr_inc(cap_last_addr) : '0;
    assign arm_rem   = cap_wrap ? CW'(DEPTH) : CW'(cap_last_addr) + CW'(1);
    assign bit_last  = first_q ? BCW'(SW - 1) : BCW'(DATA_WIDTH - 1);
    // A word that lands in the same cycle it is needed bypasses the hold register.
    assign word_src  = hold_vld_q ? hold_q : rd_data;
    // jtdi is only filler on the scan path; the unselected jscan bit is ignored.
    assign unused_inputs = ^{jtdi, jscan};

`ifdef CWC_RD_HEADER_EN
    logic [31:0] hdr_word;
    assign hdr_word   = {16'hC57A, 16'(rem_q)};
    assign first_load = {rd_data, hdr_word};
`else
    assign first_load = rd_data;
`endif

    assign jtdo    = (state_q == S_SHIFT) & shift_q[0];
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_busy = (state_q == S_PRIME) | (state_q == S_SHIFT);
    assign rd_done = (state_q == S_DONE);

    // Next-state logic: arm restarts from anywhere, loss of cap_done aborts.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        first_d    = first_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        rem_d      = rem_q;
        reads_d    = reads_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        pend_d     = rd_en_q;
        if (rd_en_q) begin
            rd_addr_d = addr_inc(rd_addr_q);
        end
        if (arm) begin
            state_d    = S_PRIME;
            pcnt_d     = 2'd0;
            rd_en_d    = 1'b1;
            rd_addr_d  = arm_start;
            rem_d      = arm_rem;
            reads_d    = arm_rem - CW'(1);
            hold_vld_d = 1'b0;
            bit_cnt_d  = '0;
            first_d    = 1'b1;
            pend_d     = 1'b0;
        end else if (!cap_done) begin
            state_d    = S_IDLE;
            hold_vld_d = 1'b0;
            pend_d     = 1'b0;
        end else begin
            case (state_q)
                S_PRIME: begin
                    if (pcnt_q != 2'd2) begin
                        pcnt_d = pcnt_q + 2'd1;
                    end else begin
                        state_d   = S_SHIFT;
                        shift_d   = first_load;
                        bit_cnt_d = '0;
                        first_d   = 1'b1;
                        if (reads_q != '0) begin
                            rd_en_d = 1'b1;
                            reads_d = reads_q - CW'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    if (pend_q && !hold_vld_q) begin
                        hold_d     = rd_data;
                        hold_vld_d = 1'b1;
                    end
                    if (sel && jshift) begin
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == bit_last) begin
                            rem_d = rem_q - CW'(1);
                            if (rem_q == CW'(1)) begin
                                state_d = S_DONE;
                            end else begin
                                shift_d    = SW'(word_src);
                                bit_cnt_d  = '0;
                                first_d    = 1'b0;
                                hold_vld_d = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (reads_q != '0 && !rd_en_q && !pend_q && !hold_vld_q) begin
                        rd_en_d = 1'b1;
                        reads_d = reads_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge jtck) begin
        if (!jrstn) begin
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            first_q    <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rem_q      <= '0;
            reads_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            first_q    <= first_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rem_q      <= rem_d;
            reads_q    <= reads_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: tb/tb_cwc_trace_reader.sv
// Bench for cwc_trace_reader: trace RAM model, word/bit reference model and
// a negedge monitor that pops expected read addresses and jtdo bits.
module tb_cwc_trace_reader;
    localparam int DW    = 14;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int SEL   = 1;

    logic          jtck = 1'b0;
    logic          jrstn;
    logic [1:0]    jscan;
    logic          jshift;
    logic          jupdate;
    logic          jtdi;
    logic          jtdo;
    logic          cap_done;
    logic          cap_wrap;
    logic [AW-1:0] cap_last_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_busy;
    logic          rd_done;

    cwc_trace_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .SCAN_SEL(SEL)
    ) dut (
        .jtck(jtck), .jrstn(jrstn), .jscan(jscan), .jshift(jshift),
        .jupdate(jupdate), .jtdi(jtdi), .jtdo(jtdo), .cap_done(cap_done),
        .cap_wrap(cap_wrap), .cap_last_addr(cap_last_addr), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_done(rd_done)
    );

    always #5 jtck = ~jtck;

    // Trace RAM: synchronous read, data one jtck after rd_en.
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'h100 + i);
    always @(posedge jtck) if (rd_en) rd_data <= mem[rd_addr[3:0]];

    int checks = 0;
    int errors = 0;
    bit bitq[$];
    int addrq[$];
    bit mon_en = 1'b0;
    int nbits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge jtck);
        #1;
    endtask

    // Reference model: which words come out, in what order, as a bit list.
    task automatic build(input bit wrap, input int last);
        int n, start, a;
        logic [31:0] h;
        logic [DW-1:0] w;
        n     = wrap ? DEPTH : last + 1;
        start = wrap ? ((last + 1) % DEPTH) : 0;
        bitq.delete();
        addrq.delete();
        nbits = 0;
`ifdef CWC_RD_HEADER_EN
        h = {16'hC57A, 16'(n)};
        for (int b = 0; b < 32; b++) begin
            bitq.push_back(h[b]);
            nbits++;
        end
`else
        h = '0;
`endif
        for (int k = 0; k < n; k++) begin
            a = (start + k) % DEPTH;
            addrq.push_back(a);
            w = DW'(32'h100 + a);
            for (int b = 0; b < DW; b++) begin
                bitq.push_back(w[b]);
                nbits++;
            end
        end
    endtask

    // Monitor: every counted shift must present the next expected bit; a
    // stalled shift must hold it; every RAM read must hit the next address.
    always @(negedge jtck) begin
        if (mon_en) begin
            if (jscan[SEL] && jshift) begin
                if (bitq.size() == 0) chk("bit_underflow", 32'd1, 32'd0);
                else chk("stream_bit", {31'd0, jtdo}, {31'd0, bitq.pop_front()});
            end else if (bitq.size() != 0) begin
                chk("hold_bit", {31'd0, jtdo}, {31'd0, bitq[0]});
            end
        end
        if (rd_en) begin
            if (addrq.size() == 0) chk("extra_read", 32'(rd_addr), 32'hFFFF_FFFF);
            else chk("read_addr", 32'(rd_addr), 32'(addrq.pop_front()));
        end
    end

    // Arm a readout and walk through the three PRIME cycles with jshift high.
    task automatic arm(input bit wrap, input int last);
        cap_wrap      = wrap;
        cap_last_addr = AW'(last);
        jscan         = 2'b10;
        jupdate       = 1'b1;
        tick();
        jupdate = 1'b0;
        mon_en  = 1'b0;
        jshift  = 1'b1;
        build(wrap, last);
        chk("arm_rd_en", {31'd0, rd_en}, 32'd1);
        chk("arm_busy", {31'd0, rd_busy}, 32'd1);
        chk("arm_done", {31'd0, rd_done}, 32'd0);
        tick();
        chk("prime_jtdo1", {31'd0, jtdo}, 32'd0);
        tick();
        chk("prime_jtdo2", {31'd0, jtdo}, 32'd0);
        tick();
        chk("shift_busy", {31'd0, rd_busy}, 32'd1);
    endtask

    task automatic stream(input int n, input int stall_at, input int stall_len,
                          input int sel_at, input int sel_len, input bit rnd, input bit full);
        mon_en = 1'b1;
        jscan  = 2'b10;
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                jshift = 1'b0;
                repeat (stall_len) tick();
            end
            if (b == sel_at) begin
                jshift = 1'b1;
                jscan  = 2'b00;
                repeat (sel_len) tick();
                jscan  = 2'b10;
            end
            if (rnd && $urandom_range(0, 7) == 0) begin
                jshift = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            jshift = 1'b1;
            jtdi   = 1'($urandom);
            if (full && b == n - 1) chk("done_early", {31'd0, rd_done}, 32'd0);
            tick();
        end
        jshift = 1'b0;
        mon_en = 1'b0;
        if (full) begin
            chk("bits_left", 32'(bitq.size()), 32'd0);
            chk("reads_left", 32'(addrq.size()), 32'd0);
            chk("rd_done", {31'd0, rd_done}, 32'd1);
            chk("busy_clear", {31'd0, rd_busy}, 32'd0);
            chk("done_jtdo", {31'd0, jtdo}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        jrstn = 1'b0; jscan = 2'b00; jshift = 1'b0; jupdate = 1'b0; jtdi = 1'b0;
        cap_done = 1'b1; cap_wrap = 1'b0; cap_last_addr = '0;
        tick();
        tick();
        chk("rst_jtdo", {31'd0, jtdo}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_busy", {31'd0, rd_busy}, 32'd0);
        chk("rst_done", {31'd0, rd_done}, 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        jrstn = 1'b1;
        tick();

        // No wrap, four words.
        arm(1'b0, 3);
        stream(nbits, -1, 0, -1, 0, 1'b0, 1'b1);
        // Shifts in DONE are ignored.
        jscan = 2'b10; jshift = 1'b1;
        tick();
        tick();
        chk("done_hold", {31'd0, rd_done}, 32'd1);
        chk("done_shift_jtdo", {31'd0, jtdo}, 32'd0);
        chk("done_no_read", {31'd0, rd_en}, 32'd0);
        jshift = 1'b0;

        // Wrapped capture: oldest sample follows the last write.
        arm(1'b1, 5);
        stream(nbits, -1, 0, -1, 0, 1'b0, 1'b1);
        // Last write at DEPTH-1: start address wraps to 0.
        arm(1'b1, 15);
        stream(nbits, -1, 0, -1, 0, 1'b0, 1'b1);
        // Host stalls: jshift low and sel low mid-word.
        arm(1'b0, 3);
        stream(nbits, 20, 5, 40, 3, 1'b0, 1'b1);

        // Reset mid-stream, then replay from the first sample.
        arm(1'b0, 3);
        stream(20, -1, 0, -1, 0, 1'b0, 1'b0);
        jrstn = 1'b0;
        tick();
        chk("abort_jtdo", {31'd0, jtdo}, 32'd0);
        chk("abort_rd_en", {31'd0, rd_en}, 32'd0);
        chk("abort_busy", {31'd0, rd_busy}, 32'd0);
        chk("abort_done", {31'd0, rd_done}, 32'd0);
        chk("abort_addr", 32'(rd_addr), 32'd0);
        jrstn = 1'b1;
        bitq.delete();
        addrq.delete();
        tick();
        arm(1'b0, 3);
        stream(nbits, -1, 0, -1, 0, 1'b0, 1'b1);

        // cap_done falling mid-SHIFT returns to IDLE.
        arm(1'b0, 3);
        stream(30, -1, 0, -1, 0, 1'b0, 1'b0);
        cap_done = 1'b0;
        tick();
        chk("capdrop_busy", {31'd0, rd_busy}, 32'd0);
        chk("capdrop_done", {31'd0, rd_done}, 32'd0);
        chk("capdrop_jtdo", {31'd0, jtdo}, 32'd0);
        chk("capdrop_rd_en", {31'd0, rd_en}, 32'd0);
        bitq.delete();
        addrq.delete();
        // Arm without cap_done is ignored.
        jscan = 2'b10; jupdate = 1'b1;
        tick();
        jupdate = 1'b0;
        chk("noarm_busy", {31'd0, rd_busy}, 32'd0);
        chk("noarm_rd_en", {31'd0, rd_en}, 32'd0);
        cap_done = 1'b1;
        tick();
        chk("noarm_idle", {31'd0, rd_busy | rd_done}, 32'd0);

        // Re-arm coinciding with the final shift: arm wins.
        arm(1'b0, 3);
        stream(nbits - 1, -1, 0, -1, 0, 1'b0, 1'b0);
        jshift = 1'b1;
        arm(1'b0, 3);
        stream(nbits, -1, 0, -1, 0, 1'b0, 1'b1);

        // Randomised captures with random host stalls.
        for (int it = 0; it < 6; it++) begin
            arm(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
            stream(nbits, -1, 0, -1, 0, 1'b1, 1'b1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
